// File: rtl/patid_bw_reg_pkg.sv
// Shared types for the per-partition bandwidth regulator: AXI/RegBus structs,
// register offsets and the burst byte-count helper.
package patid_bw_reg_pkg;

    typedef logic [31:0] cnt_t;

    typedef enum logic [31:0] {
        REG_CTRL     = 32'h0000_0000,
        REG_PERIOD   = 32'h0000_0004,
        REG_BUDGET   = 32'h0000_0008,
        REG_CONSUMED = 32'h0000_0080
    } reg_off_e;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [7:0]  user;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        axi_b_t  b;
        logic    b_valid;
        logic    ar_ready;
        axi_r_t  r;
        logic    r_valid;
    } axi_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    function automatic cnt_t burst_bytes(input logic [7:0] len, input logic [2:0] size);
        cnt_t beats;
        beats = cnt_t'(len) + cnt_t'(1);
        return beats << size;
    endfunction

    function automatic cnt_t apply_strb(input cnt_t old, input cnt_t wdata, input logic [3:0] strb);
        cnt_t res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/patid_bw_bucket.sv
// One partition's CONSUMED byte counter: saturating, cleared at window end,
// charged by up to two bursts (AW and AR) per cycle.
module patid_bw_bucket
    import patid_bw_reg_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  cnt_t budget_i,
    input  cnt_t charge_a_i,
    input  cnt_t charge_b_i,
    output cnt_t consumed_o,
    output logic allow_o
);

    cnt_t        consumed_q, consumed_d;
    cnt_t        base;
    logic [33:0] sum;

    // A charge landing in the clearing cycle starts the new window with its bytes.
    always_comb begin
        base       = clear_i ? '0 : consumed_q;
        sum        = {2'b00, base} + {2'b00, charge_a_i} + {2'b00, charge_b_i};
        consumed_d = (sum[33:32] != 2'b00) ? '1 : sum[31:0];
        allow_o    = (budget_i == '0) || (consumed_q < budget_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            consumed_q <= '0;
        end else begin
            consumed_q <= consumed_d;
        end
    end

    assign consumed_o = consumed_q;

endmodule

// File: rtl/patid_bw_regulator.sv
// Per-partition AXI bandwidth regulator: gates AW/AR by the patid's remaining
// budget in the current refresh window; W/B/R pass straight through.
module patid_bw_regulator
    import patid_bw_reg_pkg::*;
#(
    parameter int unsigned MAXPARTITION    = 16,
    parameter int unsigned AXI_USER_ID_MSB = 7,
    parameter int unsigned AXI_USER_ID_LSB = 3
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  axi_req_t slv_req_i,
    output axi_rsp_t slv_rsp_o,
    output axi_req_t mst_req_o,
    input  axi_rsp_t mst_rsp_i,
    input  reg_req_t cfg_req_i,
    output reg_rsp_t cfg_rsp_o
);

    localparam int unsigned PW = AXI_USER_ID_MSB - AXI_USER_ID_LSB + 1;

    logic                    ctrl_en_q, ctrl_en_d;
    cnt_t                    period_q, period_d;
    cnt_t                    win_q, win_d;
    cnt_t                    budget_q [MAXPARTITION];
    cnt_t                    budget_d [MAXPARTITION];
    logic                    aw_lat_q, aw_lat_d, ar_lat_q, ar_lat_d;
    cnt_t                    consumed [MAXPARTITION];
    logic [MAXPARTITION-1:0] bucket_allow, hit_aw, hit_ar, sel_budget;
    logic [PW-1:0]           patid_aw, patid_ar;
    logic                    active, rollover, period_wr;
    logic                    allow_aw, allow_ar, aw_hs, ar_hs;
    cnt_t                    bytes_aw, bytes_ar;
    logic                    reg_mapped, reg_ro, sel_ctrl, sel_period, wr_en;
    cnt_t                    reg_rdata, wr_word;

    assign patid_aw = slv_req_i.aw.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB];
    assign patid_ar = slv_req_i.ar.user[AXI_USER_ID_MSB:AXI_USER_ID_LSB];

    // Handshake rule: a beat transfers when valid && ready in the same cycle;
    // once mst ax_valid is shown it stays up until that beat, even if the
    // budget runs out underneath it (grant latch).
    always_comb begin
        active   = ctrl_en_q && (period_q != '0);
        rollover = active && (win_q >= period_q - cnt_t'(1));
        for (int p = 0; p < MAXPARTITION; p++) begin
            hit_aw[p] = (patid_aw == PW'(p));
            hit_ar[p] = (patid_ar == PW'(p));
        end
        allow_aw = !active || aw_lat_q || (hit_aw == '0) || ((hit_aw & bucket_allow) != '0);
        allow_ar = !active || ar_lat_q || (hit_ar == '0) || ((hit_ar & bucket_allow) != '0);

        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & allow_aw;
        mst_req_o.ar_valid = slv_req_i.ar_valid & allow_ar;
        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & allow_aw;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & allow_ar;

        aw_hs    = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
        ar_hs    = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
        aw_lat_d = mst_req_o.aw_valid & ~mst_rsp_i.aw_ready;
        ar_lat_d = mst_req_o.ar_valid & ~mst_rsp_i.ar_ready;
        bytes_aw = burst_bytes(slv_req_i.aw.len, slv_req_i.aw.size);
        bytes_ar = burst_bytes(slv_req_i.ar.len, slv_req_i.ar.size);
    end

    for (genvar p = 0; p < MAXPARTITION; p++) begin : g_bucket
        cnt_t charge_aw, charge_ar;
        assign charge_aw = (active && aw_hs && hit_aw[p]) ? bytes_aw : '0;
        assign charge_ar = (active && ar_hs && hit_ar[p]) ? bytes_ar : '0;

        patid_bw_bucket u_bucket (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (!active || rollover),
            .budget_i   (budget_q[p]),
            .charge_a_i (charge_aw),
            .charge_b_i (charge_ar),
            .consumed_o (consumed[p]),
            .allow_o    (bucket_allow[p])
        );
    end

    always_comb begin
        ctrl_en_d  = ctrl_en_q;
        period_d   = period_q;
        budget_d   = budget_q;
        period_wr  = 1'b0;
        reg_mapped = 1'b0;
        reg_ro     = 1'b0;
        reg_rdata  = '0;
        sel_ctrl   = 1'b0;
        sel_period = 1'b0;
        sel_budget = '0;
        cfg_rsp_o       = '0;
        cfg_rsp_o.ready = 1'b1;

        if (cfg_req_i.addr == REG_CTRL) begin
            sel_ctrl = 1'b1; reg_mapped = 1'b1; reg_rdata = {31'b0, ctrl_en_q};
        end
        if (cfg_req_i.addr == REG_PERIOD) begin
            sel_period = 1'b1; reg_mapped = 1'b1; reg_rdata = period_q;
        end
        for (int p = 0; p < MAXPARTITION; p++) begin
            if (cfg_req_i.addr == REG_BUDGET + cnt_t'(4 * p)) begin
                sel_budget[p] = 1'b1; reg_mapped = 1'b1; reg_rdata = budget_q[p];
            end
            if (cfg_req_i.addr == REG_CONSUMED + cnt_t'(4 * p)) begin
                reg_ro = 1'b1; reg_mapped = 1'b1; reg_rdata = consumed[p];
            end
        end

        wr_word = apply_strb(reg_rdata, cfg_req_i.wdata, cfg_req_i.wstrb);
        wr_en   = cfg_req_i.valid && cfg_req_i.write && reg_mapped && !reg_ro;
        if (wr_en) begin
            if (sel_ctrl) ctrl_en_d = wr_word[0];
            if (sel_period) begin
                period_d  = wr_word;
                period_wr = 1'b1;
            end
            for (int p = 0; p < MAXPARTITION; p++) begin
                if (sel_budget[p]) budget_d[p] = wr_word;
            end
        end

        if (cfg_req_i.valid) begin
            cfg_rsp_o.rdata = cfg_req_i.write ? '0 : reg_rdata;
            cfg_rsp_o.error = !reg_mapped || (cfg_req_i.write && reg_ro);
        end
    end

    always_comb begin
        if (!active || period_wr || rollover) begin
            win_d = '0;
        end else begin
            win_d = win_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en_q <= 1'b0;
            period_q  <= '0;
            win_q     <= '0;
            aw_lat_q  <= 1'b0;
            ar_lat_q  <= 1'b0;
            for (int p = 0; p < MAXPARTITION; p++) begin
                budget_q[p] <= '0;
            end
        end else begin
            ctrl_en_q <= ctrl_en_d;
            period_q  <= period_d;
            win_q     <= win_d;
            aw_lat_q  <= aw_lat_d;
            ar_lat_q  <= ar_lat_d;
            budget_q  <= budget_d;
        end
    end

endmodule

// File: tb/tb_patid_bw_regulator.sv
// Directed + randomized bench for patid_bw_regulator with a window/budget
// reference model evaluated once per clock cycle.
module tb_patid_bw_regulator;
    import patid_bw_reg_pkg::*;

    logic     clk_i;
    logic     rst_ni;
    axi_req_t slv_req, mst_req;
    axi_rsp_t slv_rsp, mst_rsp;
    reg_req_t cfg_req;
    reg_rsp_t cfg_rsp;

    int n_assert = 0;
    int n_fail   = 0;

    bit          last_hs_aw, last_hs_ar, last_mst_arv, last_cfg_err;
    logic [31:0] last_rdata;

    // reference model state
    bit          m_en;
    logic [31:0] m_period, m_win;
    logic [31:0] m_budget [16];
    logic [31:0] m_cons [16];
    bit          m_lat_aw, m_lat_ar;

    patid_bw_regulator dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp),
        .cfg_req_i (cfg_req),
        .cfg_rsp_o (cfg_rsp)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_en = 0; m_period = 0; m_win = 0; m_lat_aw = 0; m_lat_ar = 0;
        for (int p = 0; p < 16; p++) begin
            m_budget[p] = 0;
            m_cons[p]   = 0;
        end
    endtask

    function automatic longint m_bytes(input logic [7:0] len, input logic [2:0] size);
        return (longint'(len) + 1) << size;
    endfunction

    function automatic bit m_allow(input int pid, input bit lat);
        if (!(m_en && m_period != 0)) return 1'b1;
        if (lat || pid >= 16) return 1'b1;
        if (m_budget[pid] == 0) return 1'b1;
        return m_cons[pid] < m_budget[pid];
    endfunction

    task automatic m_decode(input logic [31:0] a, output bit mapped, output bit ro, output logic [31:0] val);
        mapped = 0; ro = 0; val = 0;
        if (a == 32'h0) begin
            mapped = 1; val = {31'b0, m_en};
        end else if (a == 32'h4) begin
            mapped = 1; val = m_period;
        end else if (a >= 32'h8 && a < 32'h48 && a[1:0] == 2'b00) begin
            mapped = 1; val = m_budget[int'((a - 32'h8) >> 2)];
        end else if (a >= 32'h80 && a < 32'hC0 && a[1:0] == 2'b00) begin
            mapped = 1; ro = 1; val = m_cons[int'((a - 32'h80) >> 2)];
        end
    endtask

    // One clock: check outputs at negedge against the model, advance the model at posedge.
    task automatic step();
        int          paw, par;
        bit          ok_aw, ok_ar, e_awv, e_arv, hs_aw, hs_ar, act, roll, mp, ro;
        logic [31:0] val;
        longint      sum;
        @(negedge clk_i);
        paw   = int'(slv_req.aw.user[7:3]);
        par   = int'(slv_req.ar.user[7:3]);
        ok_aw = m_allow(paw, m_lat_aw);
        ok_ar = m_allow(par, m_lat_ar);
        e_awv = slv_req.aw_valid && ok_aw;
        e_arv = slv_req.ar_valid && ok_ar;
        check("mst_aw_valid", 32'(mst_req.aw_valid), 32'(e_awv));
        check("mst_ar_valid", 32'(mst_req.ar_valid), 32'(e_arv));
        check("slv_aw_ready", 32'(slv_rsp.aw_ready), 32'(mst_rsp.aw_ready && ok_aw));
        check("slv_ar_ready", 32'(slv_rsp.ar_ready), 32'(mst_rsp.ar_ready && ok_ar));
        check("aw_addr_pass", mst_req.aw.addr, slv_req.aw.addr);
        check("w_valid_pass", 32'(mst_req.w_valid), 32'(slv_req.w_valid));
        check("r_valid_pass", 32'(slv_rsp.r_valid), 32'(mst_rsp.r_valid));
        check("cfg_ready", 32'(cfg_rsp.ready), 32'd1);
        m_decode(cfg_req.addr, mp, ro, val);
        if (cfg_req.valid) begin
            if (cfg_req.write) begin
                check("cfg_wr_err", 32'(cfg_rsp.error), 32'(!mp || ro));
            end else if (mp) begin
                check("cfg_rdata", cfg_rsp.rdata, val);
                check("cfg_rd_err", 32'(cfg_rsp.error), 32'd0);
            end
            last_cfg_err = cfg_rsp.error;
            last_rdata   = cfg_rsp.rdata;
        end
        hs_aw        = e_awv && mst_rsp.aw_ready;
        hs_ar        = e_arv && mst_rsp.ar_ready;
        last_hs_aw   = hs_aw;
        last_hs_ar   = hs_ar;
        last_mst_arv = mst_req.ar_valid;
        @(posedge clk_i);
        act  = m_en && (m_period != 0);
        roll = act && (m_win == m_period - 1);
        for (int p = 0; p < 16; p++) begin
            if (!act) begin
                m_cons[p] = 0;
            end else begin
                sum = roll ? 0 : longint'(m_cons[p]);
                if (hs_aw && paw == p) sum += m_bytes(slv_req.aw.len, slv_req.aw.size);
                if (hs_ar && par == p) sum += m_bytes(slv_req.ar.len, slv_req.ar.size);
                m_cons[p] = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
            end
        end
        m_win    = (!act || roll) ? 0 : m_win + 1;
        m_lat_aw = e_awv && !mst_rsp.aw_ready;
        m_lat_ar = e_arv && !mst_rsp.ar_ready;
        if (cfg_req.valid && cfg_req.write && mp && !ro) begin
            if (cfg_req.addr == 32'h0) m_en = cfg_req.wdata[0];
            else if (cfg_req.addr == 32'h4) begin
                m_period = cfg_req.wdata;
                m_win    = 0;
            end else m_budget[int'((cfg_req.addr - 32'h8) >> 2)] = cfg_req.wdata;
        end
        #1;
    endtask

    task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data);
        cfg_req.valid = 1; cfg_req.write = 1; cfg_req.addr = addr;
        cfg_req.wdata = data; cfg_req.wstrb = 4'hF;
        step();
        cfg_req.valid = 0; cfg_req.write = 0;
    endtask

    task automatic cfg_read(input logic [31:0] addr);
        cfg_req.valid = 1; cfg_req.write = 0; cfg_req.addr = addr;
        step();
        cfg_req.valid = 0;
    endtask

    task automatic set_aw(input bit v, input int pid, input int len, input int size);
        slv_req.aw_valid = v;
        slv_req.aw.user  = {5'(pid), 3'($urandom_range(0, 7))};
        slv_req.aw.len   = 8'(len);
        slv_req.aw.size  = 3'(size);
        slv_req.aw.addr  = $urandom;
    endtask

    task automatic set_ar(input bit v, input int pid, input int len, input int size);
        slv_req.ar_valid = v;
        slv_req.ar.user  = {5'(pid), 3'($urandom_range(0, 7))};
        slv_req.ar.len   = 8'(len);
        slv_req.ar.size  = 3'(size);
        slv_req.ar.addr  = $urandom;
    endtask

    // Random AXI-legal traffic: a shown request keeps its payload until it transfers.
    task automatic rand_traffic(input int n, input bit with_cfg);
        for (int i = 0; i < n; i++) begin
            if (!slv_req.aw_valid || last_hs_aw)
                set_aw(1'($urandom_range(0, 1)), $urandom_range(0, 19), $urandom_range(0, 7), $urandom_range(0, 3));
            if (!slv_req.ar_valid || last_hs_ar)
                set_ar(1'($urandom_range(0, 1)), $urandom_range(0, 19), $urandom_range(0, 7), $urandom_range(0, 3));
            mst_rsp.aw_ready = 1'($urandom_range(0, 1));
            mst_rsp.ar_ready = 1'($urandom_range(0, 1));
            mst_rsp.r_valid  = 1'($urandom_range(0, 1));
            slv_req.w_valid  = 1'($urandom_range(0, 1));
            if (with_cfg && $urandom_range(0, 5) == 0) begin
                cfg_req.valid = 1;
                cfg_req.wstrb = 4'hF;
                if ($urandom_range(0, 1) == 0) begin
                    cfg_req.write = 0;
                    cfg_req.addr  = 32'h80 + 32'(4 * $urandom_range(0, 15));
                end else begin
                    cfg_req.write = 1;
                    cfg_req.addr  = 32'h8 + 32'(4 * $urandom_range(0, 15));
                    cfg_req.wdata = 32'($urandom_range(0, 120));
                end
            end
            step();
            cfg_req.valid = 0; cfg_req.write = 0;
        end
        slv_req.aw_valid = 0; slv_req.ar_valid = 0; slv_req.w_valid = 0;
        mst_rsp.r_valid  = 0;
    endtask

    initial begin
        int  cyc;
        bit  done;
        slv_req = '0; mst_rsp = '0; cfg_req = '0;
        last_hs_aw = 0; last_hs_ar = 0; last_mst_arv = 0; last_cfg_err = 0; last_rdata = 0;
        m_reset();

        // reset state: config response idle, AW bypassed
        rst_ni = 0;
        slv_req.aw_valid = 1;
        #1;
        check("rst_cfg_ready", 32'(cfg_rsp.ready), 32'd1);
        check("rst_cfg_rdata", cfg_rsp.rdata, 32'd0);
        check("rst_cfg_error", 32'(cfg_rsp.error), 32'd0);
        check("rst_aw_bypass", 32'(mst_req.aw_valid), 32'd1);
        slv_req.aw_valid = 0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        cfg_read(32'h0);  check("rst_ctrl", last_rdata, 32'd0);
        cfg_read(32'h4);  check("rst_period", last_rdata, 32'd0);
        cfg_read(32'h8);  check("rst_budget0", last_rdata, 32'd0);

        // bypass with enable=0
        cfg_write(32'h8, 32'd16);
        rand_traffic(50, 1'b0);
        for (int p = 0; p < 16; p += 5) begin
            cfg_read(32'h80 + 32'(4 * p));
            check("bypass_consumed", last_rdata, 32'd0);
        end
        cfg_write(32'h8, 32'd0);

        // exhaustion of patid 2 and recovery at window rollover
        cfg_write(32'h4, 32'd100);
        cfg_write(32'h10, 32'd64);
        cfg_write(32'h0, 32'd1);
        mst_rsp.ar_ready = 1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0; done = 0;
            set_ar(1, 2, 3, 3);
            while (!done && cyc < 200) begin
                step();
                cyc++;
                done = last_hs_ar;
            end
            check("exh_admitted", 32'(done), 32'd1);
            if (k < 2) check("exh_no_stall", 32'(cyc), 32'd1);
            else       check("exh_stalled", 32'(cyc > 1), 32'd1);
            slv_req.ar_valid = 0;
        end
        cfg_read(32'h88);
        check("exh_consumed2", last_rdata, 32'd32);

        // simultaneous AW (16 B) + AR (32 B) on patid 1
        cfg_write(32'hC, 32'd100);
        set_aw(1, 1, 1, 3);
        set_ar(1, 1, 3, 3);
        mst_rsp.aw_ready = 1; mst_rsp.ar_ready = 1;
        step();
        check("sim_aw_hs", 32'(last_hs_aw), 32'd1);
        check("sim_ar_hs", 32'(last_hs_ar), 32'd1);
        slv_req.aw_valid = 0; slv_req.ar_valid = 0;
        cfg_read(32'h84);
        check("sim_consumed1", last_rdata, 32'd48);

        // grant latch on patid 4
        set_ar(1, 4, 0, 3);
        step();
        check("lat_pre_hs", 32'(last_hs_ar), 32'd1);
        mst_rsp.ar_ready = 0;
        set_ar(1, 4, 0, 3);
        step();
        check("lat_pending", 32'(last_mst_arv), 32'd1);
        cfg_write(32'h18, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lat_held", 32'(last_mst_arv), 32'd1);
        end
        mst_rsp.ar_ready = 1;
        step();
        check("lat_hs", 32'(last_hs_ar), 32'd1);
        set_ar(1, 4, 0, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("lat_next_stalled", 32'(last_mst_arv), 32'd0);
        end
        slv_req.ar_valid = 0;

        // unregulated patid and error responses
        for (int p = 0; p < 16; p++) cfg_write(32'h8 + 32'(4 * p), 32'd64);
        for (int i = 0; i < 10; i++) begin
            set_ar(1, 20, 7, 3);
            step();
            check("unreg_arv", 32'(last_mst_arv), 32'd1);
        end
        slv_req.ar_valid = 0;
        cfg_write(32'h80, 32'h1234);
        check("err_ro_write", 32'(last_cfg_err), 32'd1);
        cfg_write(32'h200, 32'h1234);
        check("err_unmapped_write", 32'(last_cfg_err), 32'd1);
        cfg_write(32'h8, 32'd64);
        check("ok_budget_write", 32'(last_cfg_err), 32'd0);

        // randomized regulated traffic with live budget changes
        cfg_write(32'h4, 32'd37);
        for (int p = 0; p < 16; p++)
            cfg_write(32'h8 + 32'(4 * p), ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(8, 120)));
        rand_traffic(400, 1'b1);

        // reset in the middle of a window
        cfg_write(32'h0, 32'd0);
        cfg_write(32'h4, 32'd1000);
        cfg_write(32'h14, 32'd0);
        cfg_write(32'h0, 32'd1);
        mst_rsp.ar_ready = 1;
        set_ar(1, 3, 4, 3);
        step();
        check("rst_pre_hs", 32'(last_hs_ar), 32'd1);
        slv_req.ar_valid = 0;
        cfg_read(32'h8C);
        check("rst_pre_consumed3", last_rdata, 32'd40);
        rst_ni = 0;
        m_reset();
        set_ar(1, 3, 4, 3);
        #1;
        check("rst_mid_bypass", 32'(mst_req.ar_valid), 32'd1);
        slv_req.ar_valid = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        @(posedge clk_i);
        #1;
        cfg_read(32'h0); check("post_rst_ctrl", last_rdata, 32'd0);
        cfg_read(32'h4); check("post_rst_period", last_rdata, 32'd0);
        for (int p = 0; p < 16; p++) begin
            cfg_read(32'h8 + 32'(4 * p));
            check("post_rst_budget", last_rdata, 32'd0);
            cfg_read(32'h80 + 32'(4 * p));
            check("post_rst_consumed", last_rdata, 32'd0);
        end
        rand_traffic(30, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
